// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// the memory-freeze FSM states and a helper for sizing the wait counter.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_t;

  // Wait counter width is ceil(log2(latency)) with a floor of one bit so
  // the single-cycle memory configuration still has a legal register.
  function automatic int waitCntWidth(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding comparator for one E-stage ALU operand. The M stage result is
// newer than the W stage result, so it wins; x0 is hardwired and never
// forwarded.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regwriteM,
  input  logic              regwriteW,
  output logic [1:0]        fwd
);

  fwd_sel_t sel;

  // Priority compare: M first, then W, otherwise the register file value.
  always_comb begin
    sel = FWD_RF;
    if (regwriteM && (rdM != '0) && (rdM == rsE)) begin
      sel = FWD_M;
    end else if (regwriteW && (rdW != '0) && (rdW == rsE)) begin
      sel = FWD_W;
    end
    fwd = sel;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use
// stall, taken-branch flush, a whole-pipe freeze while a multi-cycle memory
// op sits in M, and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              resultsrcE,
  input  logic              memopM,
  input  logic              pcsrcE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushW,
  output logic [1:0]        fwdAE,
  output logic [1:0]        fwdBE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int CW          = waitCntWidth(MEM_LATENCY);
  localparam int WAIT_INIT_I = (MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0;
  localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_INIT_I);

  hz_state_t        state;
  hz_state_t        stateNext;
  logic [CW-1:0]    waitCnt;
  logic [CW-1:0]    waitCntNext;
  logic             freeze;
  logic             loadUse;
  logic             branchFlush;
  logic             unusedRegwriteE;

  // regwriteE is part of the pipeline interface but no hazard depends on it.
  assign unusedRegwriteE = regwriteE;

  fwd_sel #(.REG_AW(REG_AW)) uFwdA (
    .rsE       (rs1E),
    .rdM       (rdM),
    .rdW       (rdW),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .fwd       (fwdAE)
  );

  fwd_sel #(.REG_AW(REG_AW)) uFwdB (
    .rsE       (rs2E),
    .rdM       (rdM),
    .rdW       (rdW),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .fwd       (fwdBE)
  );

  // Freeze FSM state and wait counter; reset abandons any op in M.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  // Freeze for MEM_LATENCY-1 cycles: the entry cycle plus WAIT_INIT more
  // counted cycles in MEMWAIT, then a release cycle in which M drains.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    freeze      = 1'b0;
    case (state)
      RUN: begin
        if (memopM && (MEM_LATENCY > 1)) begin
          freeze      = 1'b1;
          stateNext   = MEMWAIT;
          waitCntNext = WAIT_INIT;
        end
      end
      MEMWAIT: begin
        if (waitCnt != '0) begin
          freeze      = 1'b1;
          waitCntNext = waitCnt - CW'(1);
        end else begin
          stateNext = RUN;
        end
      end
      default: begin
        stateNext = RUN;
      end
    endcase
    if (rst) begin
      freeze = 1'b0;
    end
  end

  // Stall/flush generation; a branch squashes the dependent instruction so
  // it overrides load-use, and both are held off while the pipe is frozen.
  always_comb begin
    loadUse     = resultsrcE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
    branchFlush = pcsrcE && !freeze && !rst;
    stallF      = freeze || (loadUse && !pcsrcE && !freeze && !rst);
    stallD      = stallF;
    stallE      = freeze;
    stallM      = freeze;
    flushW      = freeze;
    flushD      = branchFlush;
    flushE      = !freeze && !rst && (pcsrcE || loadUse);
  end

  // Saturating performance counters for stall and branch-flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallF && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (branchFlush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
